// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nn_pkg
//  Description : Shared widths and the sequencer state encoding for the
//                fully connected layer sequencer and its activation stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package nn_pkg;

   localparam int FAN_IN  = 20;                   // inputs per neuron
   localparam int IN_W    = 16;                   // signed input element width
   localparam int W_W     = 8;                    // signed weight / bias width
   localparam int ACC_W   = 32;                   // signed accumulator width
   localparam int X_BUS_W = FAN_IN * IN_W;        // 320-bit input vector bus
   localparam int W_BUS_W = FAN_IN * W_W + W_W;   // 168-bit weights + bias bus

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_WAIT  = 3'd2,
      S_CALC  = 3'd3,
      S_EMIT  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

endpackage
`default_nettype wire

// File: rtl/nn_act.sv
`default_nettype none
// ============================================================================
//  Module      : nn_act
//  Description : Activation stage applied to each neuron sum before it is
//                registered. Build macro NEURON_RELU_EN selects ReLU;
//                without it the sum passes through unchanged.
//  Revision    : 1.0 - initial release
// ============================================================================
module nn_act
   import nn_pkg::*;
(
   input  logic signed [ACC_W-1:0] i_sum,
   output logic signed [ACC_W-1:0] o_act
);

   // Purely combinational: clamp negatives to zero, or pass through.
   always_comb begin
`ifdef NEURON_RELU_EN
      o_act = i_sum[ACC_W-1] ? '0 : i_sum;
`else
      o_act = i_sum;
`endif
   end

endmodule
`default_nettype wire

// File: rtl/neuron_layer_seq.sv
`default_nettype none
// ============================================================================
//  Module      : neuron_layer_seq
//  Description : Time-multiplexes one external 20-input neuron datapath over
//                NUM_NEURONS neurons. Latches the input vector on start,
//                fetches each neuron's weights from a 1-cycle synchronous ROM,
//                registers the datapath sum and streams results out with a
//                valid/ready handshake. Build macro NEURON_RELU_EN enables a
//                ReLU on the stored result (same latency either way).
//  Revision    : 1.0 - initial release
// ============================================================================
module neuron_layer_seq
   import nn_pkg::*;
#(
   parameter int NUM_NEURONS = 10,
   parameter int IDX_W       = 4
)
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_start,
   input  logic [X_BUS_W-1:0]       i_x_vec,
   output logic                     o_busy,
   output logic [IDX_W-1:0]         o_w_addr,
   output logic                     o_w_rd,
   input  logic [W_BUS_W-1:0]       i_w_data,
   output logic [X_BUS_W-1:0]       o_nrn_x,
   output logic [W_BUS_W-1:0]       o_nrn_w,
   input  logic signed [ACC_W-1:0]  i_nrn_sum,
   output logic                     o_out_valid,
   input  logic                     i_out_ready,
   output logic signed [ACC_W-1:0]  o_out_data,
   output logic [IDX_W-1:0]         o_out_idx,
   output logic                     o_done
);

   state_t                   r_state;
   state_t                   w_next_state;
   logic [X_BUS_W-1:0]       r_x;
   logic [W_BUS_W-1:0]       r_w;
   logic [IDX_W-1:0]         r_idx;
   logic signed [ACC_W-1:0]  r_out_data;
   logic [IDX_W-1:0]         r_out_idx;
   logic signed [ACC_W-1:0]  w_act;
   logic                     w_last;

   assign w_last     = (r_idx == IDX_W'(NUM_NEURONS - 1));
   assign o_w_addr   = r_idx;
   assign o_nrn_x    = r_x;
   assign o_nrn_w    = r_w;
   assign o_out_data = r_out_data;
   assign o_out_idx  = r_out_idx;

   nn_act u_act (
      .i_sum (i_nrn_sum),
      .o_act (w_act)
   );

   // State register; reset aborts any pass in progress without a done pulse.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next_state;
   end

   // Next-state decode and per-state output strobes.
   always_comb begin
      w_next_state = r_state;
      o_busy       = 1'b1;
      o_w_rd       = 1'b0;
      o_out_valid  = 1'b0;
      o_done       = 1'b0;
      case (r_state)
         S_IDLE: begin
            o_busy = 1'b0;
            if (i_start) w_next_state = S_FETCH;
         end
         S_FETCH: begin
            o_w_rd       = 1'b1;
            w_next_state = S_WAIT;
         end
         S_WAIT:  w_next_state = S_CALC;
         S_CALC:  w_next_state = S_EMIT;
         S_EMIT: begin
            o_out_valid = 1'b1;
            if (i_out_ready) w_next_state = w_last ? S_DONE : S_FETCH;
         end
         S_DONE: begin
            o_done       = 1'b1;
            w_next_state = S_IDLE;
         end
         default: begin
            o_busy       = 1'b0;
            w_next_state = S_IDLE;
         end
      endcase
   end

   // Datapath registers: vector latch, weight latch, neuron index, result.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_x        <= '0;
         r_w        <= '0;
         r_idx      <= '0;
         r_out_data <= '0;
         r_out_idx  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_x   <= i_x_vec;
                  r_idx <= '0;
               end
            end
            S_WAIT: r_w <= i_w_data;
            S_CALC: begin
               // Sum is sampled one cycle after the weight latch loads.
               r_out_data <= w_act;
               r_out_idx  <= r_idx;
            end
            S_EMIT: begin
               if (i_out_ready && !w_last) r_idx <= r_idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_neuron_layer_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_neuron_layer_seq
//  Description : Self-checking bench for neuron_layer_seq with a 3-neuron
//                layer, a synchronous ROM model and a combinational dot
//                product datapath model. Honours NEURON_RELU_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_neuron_layer_seq;
   import nn_pkg::*;

   localparam int NN = 3;
   localparam int IW = 4;

   logic                     clk;
   logic                     rst;
   logic                     i_start;
   logic [X_BUS_W-1:0]       i_x_vec;
   logic                     o_busy;
   logic [IW-1:0]            o_w_addr;
   logic                     o_w_rd;
   logic [W_BUS_W-1:0]       i_w_data;
   logic [X_BUS_W-1:0]       o_nrn_x;
   logic [W_BUS_W-1:0]       o_nrn_w;
   logic signed [ACC_W-1:0]  i_nrn_sum;
   logic                     o_out_valid;
   logic                     i_out_ready;
   logic signed [ACC_W-1:0]  o_out_data;
   logic [IW-1:0]            o_out_idx;
   logic                     o_done;

   logic [W_BUS_W-1:0]       rom [0:15];
   int                       n_checks;
   int                       n_fail;

   neuron_layer_seq #(.NUM_NEURONS(NN), .IDX_W(IW)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_start     (i_start),
      .i_x_vec     (i_x_vec),
      .o_busy      (o_busy),
      .o_w_addr    (o_w_addr),
      .o_w_rd      (o_w_rd),
      .i_w_data    (i_w_data),
      .o_nrn_x     (o_nrn_x),
      .o_nrn_w     (o_nrn_w),
      .i_nrn_sum   (i_nrn_sum),
      .o_out_valid (o_out_valid),
      .i_out_ready (i_out_ready),
      .o_out_data  (o_out_data),
      .o_out_idx   (o_out_idx),
      .o_done      (o_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Signed dot product of 20 inputs with 20 weights, plus bias.
   function automatic logic signed [31:0] dot(input logic [X_BUS_W-1:0] x,
                                              input logic [W_BUS_W-1:0] w);
      longint s;
      s = longint'($signed(w[160 +: 8]));
      for (int i = 0; i < FAN_IN; i++)
         s += longint'($signed(x[16*i +: 16])) * longint'($signed(w[8*i +: 8]));
      return s[31:0];
   endfunction

   // Expected stored result: dot product, optionally rectified.
   function automatic logic signed [31:0] model(input logic [X_BUS_W-1:0] x,
                                                input logic [W_BUS_W-1:0] w);
      logic signed [31:0] r;
      r = dot(x, w);
`ifdef NEURON_RELU_EN
      if (r < 0) r = 0;
`endif
      return r;
   endfunction

   // Synchronous ROM with one cycle read latency.
   always @(posedge clk) if (o_w_rd) i_w_data <= rom[o_w_addr];

   // External combinational datapath.
   always_comb i_nrn_sum = dot(o_nrn_x, o_nrn_w);

   // One full layer pass started from IDLE. mode 0: ready always high;
   // mode 1: stall stall_n cycles on neuron stall_k; mode 2: random ready.
   task automatic run_pass(input int mode, input int stall_k, input int stall_n,
                           input bit extra_start, output int done_cyc,
                           output logic signed [31:0] first_data);
      logic [X_BUS_W-1:0]  xs;
      logic signed [31:0]  exp_d [NN];
      int cyc, k, exp_valid, exp_done, stall_left;
      bit fin, vexp, wexp, dexp, rdy;
      @(negedge clk);
      xs = i_x_vec;
      i_start = 1'b1;
      i_out_ready = 1'b1;
      for (int j = 0; j < NN; j++) exp_d[j] = model(xs, rom[j]);
      k = 0; exp_valid = 4; exp_done = -1; stall_left = stall_n;
      fin = 1'b0; cyc = 0; done_cyc = -1; first_data = '0;
      while (!fin) begin
         @(negedge clk);
         cyc++;
         i_start = extra_start && (cyc == 6);
         i_x_vec = {10{$urandom()}};
         vexp = (k < NN) && (cyc >= exp_valid);
         wexp = (k < NN) && (cyc == exp_valid - 3);
         dexp = (cyc == exp_done);
         n_checks++;
         if (o_out_valid !== vexp) begin
            n_fail++;
            $display("FAIL out_valid cyc=%0d got=%b want=%b", cyc, o_out_valid, vexp);
         end
         if (vexp) begin
            n_checks++;
            if (o_out_data !== exp_d[k] || o_out_idx !== IW'(k)) begin
               n_fail++;
               $display("FAIL out_data cyc=%0d got=%0d/idx%0d want=%0d/idx%0d",
                        cyc, o_out_data, o_out_idx, exp_d[k], k);
            end
            if (k == 0) first_data = o_out_data;
         end
         n_checks++;
         if (o_w_rd !== wexp || (wexp && o_w_addr !== IW'(k))) begin
            n_fail++;
            $display("FAIL w_rd cyc=%0d got=%b/addr%0d want=%b/addr%0d",
                     cyc, o_w_rd, o_w_addr, wexp, k);
         end
         n_checks++;
         if (o_done !== dexp || o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL done_busy cyc=%0d got=%b/%b want=%b/1", cyc, o_done, o_busy, dexp);
         end
         if (dexp) begin
            done_cyc = cyc;
            fin = 1'b1;
         end
         case (mode)
            1: begin
               rdy = !(vexp && k == stall_k && stall_left > 0);
               if (!rdy) stall_left--;
            end
            2:       rdy = ($urandom_range(0, 3) != 0);
            default: rdy = 1'b1;
         endcase
         i_out_ready = rdy;
         if (vexp && rdy) begin
            k++;
            exp_valid = cyc + 4;
            if (k == NN) exp_done = cyc + 1;
         end
         if (cyc > 400 && !fin) begin
            n_fail++;
            $display("FAIL timeout cyc=%0d got=no done want=done", cyc);
            fin = 1'b1;
         end
      end
      @(negedge clk);
      n_checks++;
      if (o_busy !== 1'b0 || o_done !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_after_done got busy=%b done=%b want=0/0", o_busy, o_done);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; i_start = 1'b0; i_out_ready = 1'b0;
      i_x_vec = {10{$urandom()}};
      repeat (2) @(negedge clk);
      n_checks++;
      if ({o_busy, o_w_rd, o_out_valid, o_done} !== 4'b0 || o_w_addr !== '0 ||
          o_out_idx !== '0 || o_out_data !== '0 || o_nrn_x !== '0 || o_nrn_w !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs got busy=%b rd=%b v=%b d=%b data=%0d want all 0",
                  o_busy, o_w_rd, o_out_valid, o_done, o_out_data);
      end
      rst = 1'b0; i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      n_checks++;
      if (o_busy !== 1'b1 || o_w_rd !== 1'b1 || o_w_addr !== '0) begin
         n_fail++;
         $display("FAIL start_after_reset got busy=%b rd=%b want 1/1", o_busy, o_w_rd);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int dc; logic signed [31:0] fd;
      i_x_vec = {20{16'sd1}};
      for (int k = 0; k < NN; k++) rom[k] = {8'(k), {20{8'(k + 1)}}};
      run_pass(0, 0, 0, 1'b0, dc, fd);
      n_checks++;
      if (dc !== 13 || fd !== 32'sd20) begin
         n_fail++;
         $display("FAIL basic_timing got done=%0d first=%0d want 13/20", dc, fd);
      end
   endtask

   task automatic test_backpressure();
      int dc; logic signed [31:0] fd;
      i_x_vec = {20{16'sd1}};
      run_pass(1, 1, 5, 1'b0, dc, fd);
      n_checks++;
      if (dc !== 18) begin
         n_fail++;
         $display("FAIL backpressure_done got=%0d want=18", dc);
      end
   endtask

   task automatic test_sign();
      int dc; logic signed [31:0] fd, want;
      i_x_vec = {20{16'h8000}};
      for (int k = 0; k < NN; k++) rom[k] = {8'h80, {20{8'h7F}}};
`ifdef NEURON_RELU_EN
      want = 32'sd0;
`else
      want = -32'sd83230848;
`endif
      run_pass(0, 0, 0, 1'b0, dc, fd);
      n_checks++;
      if (fd !== want) begin
         n_fail++;
         $display("FAIL sign got=%0d want=%0d", fd, want);
      end
   endtask

   task automatic test_random();
      int dc; logic signed [31:0] fd;
      for (int p = 0; p < 4; p++) begin
         for (int i = 0; i < FAN_IN; i++) i_x_vec[16*i +: 16] = 16'($urandom());
         for (int k = 0; k < NN; k++)
            for (int i = 0; i < FAN_IN + 1; i++) rom[k][8*i +: 8] = 8'($urandom());
         run_pass(2, 0, 0, 1'b0, dc, fd);
      end
   endtask

   task automatic test_start_busy_reset();
      logic [X_BUS_W-1:0] xs;
      for (int i = 0; i < FAN_IN; i++) i_x_vec[16*i +: 16] = 16'($urandom());
      for (int k = 0; k < NN; k++) rom[k] = {8'(3 * k + 1), {20{8'(k + 2)}}};
      @(negedge clk);
      xs = i_x_vec; i_start = 1'b1; i_out_ready = 1'b1;
      for (int cyc = 1; cyc <= 10; cyc++) begin
         @(negedge clk);
         i_start = (cyc == 6);
         i_x_vec = {10{$urandom()}};
         if (cyc == 8) begin
            n_checks++;
            if (o_out_valid !== 1'b1 || o_out_idx !== IW'(1) || o_out_data !== model(xs, rom[1])) begin
               n_fail++;
               $display("FAIL extra_start got v=%b idx=%0d data=%0d want 1/1/%0d",
                        o_out_valid, o_out_idx, o_out_data, model(xs, rom[1]));
            end
         end
         if (cyc == 10) begin
            n_checks++;
            if (o_busy !== 1'b1 || o_out_valid !== 1'b0 || o_w_rd !== 1'b0) begin
               n_fail++;
               $display("FAIL wait_n2 got busy=%b v=%b rd=%b want 1/0/0", o_busy, o_out_valid, o_w_rd);
            end
            rst = 1'b1;
         end
      end
      @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if (o_out_valid !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0 ||
          o_out_data !== '0 || o_nrn_x !== '0) begin
         n_fail++;
         $display("FAIL mid_reset got v=%b busy=%b done=%b data=%0d want 0/0/0/0",
                  o_out_valid, o_busy, o_done, o_out_data);
      end
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         n_checks++;
         if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle got done=%b busy=%b want 0/0", o_done, o_busy);
         end
      end
   endtask

   initial begin
      n_checks = 0; n_fail = 0;
      rst = 1'b1; i_start = 1'b0; i_out_ready = 1'b0;
      i_x_vec = '0; i_w_data = '0;
      for (int k = 0; k < 16; k++) rom[k] = '0;
      test_reset();
      test_basic();
      test_backpressure();
      test_sign();
      test_random();
      test_start_busy_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
